// File: rtl/clkgen_multi.sv
`default_nettype none
// ============================================================================
// Module  : clkgen_multi
// Brief   : Multi-channel programmable clock divider with phase alignment and lock.
// Revision: 1.0
// ============================================================================
module clkgen_multi #(
    parameter int NUM_CLOCKS    = 2,
    parameter int CNT_W         = 16,
    parameter int DEF_DIV       = 5,
    parameter int LOCK_CYCLES   = 256,
    parameter int GATE_UNLOCKED = 1
) (
    input  logic                  refclk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [4:0]            cfg_chan,
    input  logic [CNT_W-1:0]      cfg_div,
    input  logic [CNT_W-1:0]      cfg_high,
    input  logic [CNT_W-1:0]      cfg_phase,
    output logic                  cfg_err,
    output logic [NUM_CLOCKS-1:0] outclk,
    output logic                  locked
);

    localparam int               LW        = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LW-1:0]    LOCK_LAST = LW'(LOCK_CYCLES - 1);
    localparam logic [4:0]       NCH       = 5'(NUM_CLOCKS);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_DIV   = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] RST_HIGH  = CNT_W'((DEF_DIV / 2 < 1) ? 1 : DEF_DIV / 2);

    typedef enum logic [1:0] {
        ST_LOCKING = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_APPLY   = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [LW-1:0]           lock_q, lock_d;
    logic                    locked_q, locked_d;
    logic                    ready_q;
    logic                    err_q;
    logic [NUM_CLOCKS-1:0]   outclk_q, outclk_d;

    logic accept;
    logic legal;
    logic wr_en;
    logic apply;

    assign accept = cfg_valid & ready_q;
    assign legal  = (cfg_chan < NCH) && (cfg_div >= CNT_W'(2)) && (cfg_high != '0)
                 && (cfg_high < cfg_div) && (cfg_phase < cfg_div);
    assign wr_en  = accept & legal;
    assign apply  = (state_q == ST_APPLY);

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        case (state_q)
            ST_LOCKING: begin
                lock_d = lock_q + 1'b1;
                if (wr_en)
                    state_d = ST_APPLY;
                else if (lock_q == LOCK_LAST)
                    state_d = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (wr_en)
                    state_d = ST_APPLY;
            end
            ST_APPLY: begin
                state_d = ST_LOCKING;
                lock_d  = '0;
            end
            default: begin
                state_d = ST_LOCKING;
                lock_d  = '0;
            end
        endcase
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_LOCKING;
            lock_q   <= '0;
            locked_q <= 1'b0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            outclk_q <= '0;
        end else begin
            state_q  <= state_d;
            lock_q   <= lock_d;
            locked_q <= locked_d;
            ready_q  <= (state_d != ST_APPLY);
            err_q    <= accept & ~legal;
            outclk_q <= outclk_d;
        end
    end

    for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
        logic [CNT_W-1:0] div_q, high_q, phase_q;
        logic [CNT_W-1:0] sdiv_q, shigh_q, sphase_q;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] div_d, high_d, phase_d;
        logic             sel;

        assign sel = wr_en && (cfg_chan == 5'(i));

        // On the APPLY exit edge the counter is preloaded so that it wraps
        // exactly phase cycles later, giving all channels a common reference.
        always_comb begin
            div_d   = div_q;
            high_d  = high_q;
            phase_d = phase_q;
            cnt_d   = (cnt_q == div_q - ONE) ? '0 : cnt_q + ONE;
            if (apply) begin
                div_d   = sdiv_q;
                high_d  = shigh_q;
                phase_d = sphase_q;
                cnt_d   = (sphase_q == '0) ? '0 : sdiv_q - sphase_q;
            end
        end

        always_ff @(posedge refclk or negedge rst_n) begin
            if (!rst_n) begin
                div_q    <= RST_DIV;
                high_q   <= RST_HIGH;
                phase_q  <= '0;
                sdiv_q   <= RST_DIV;
                shigh_q  <= RST_HIGH;
                sphase_q <= '0;
                cnt_q    <= '0;
            end else begin
                if (sel) begin
                    sdiv_q   <= cfg_div;
                    shigh_q  <= cfg_high;
                    sphase_q <= cfg_phase;
                end
                div_q   <= div_d;
                high_q  <= high_d;
                phase_q <= phase_d;
                cnt_q   <= cnt_d;
            end
        end

        assign outclk_d[i] = (cnt_d < high_d) & ((GATE_UNLOCKED != 0) ? locked_d : 1'b1);
    end

    assign cfg_ready = ready_q;
    assign cfg_err   = err_q;
    assign locked    = locked_q;
    assign outclk    = outclk_q;

endmodule
`default_nettype wire

// File: tb/tb_clkgen_multi.sv
`default_nettype none
// ============================================================================
// Module  : tb_clkgen_multi
// Brief   : Randomized bench for clkgen_multi, gated and ungated instances.
// Revision: 1.0
// ============================================================================
module tb_clkgen_multi;

    localparam int NCH  = 2;
    localparam int CW   = 16;
    localparam int DEFD = 5;
    localparam int LC   = 8;

    logic            refclk = 1'b0;
    logic            rst_n  = 1'b1;
    logic            cfg_valid = 1'b0;
    logic [4:0]      cfg_chan  = '0;
    logic [CW-1:0]   cfg_div   = '0;
    logic [CW-1:0]   cfg_high  = '0;
    logic [CW-1:0]   cfg_phase = '0;
    logic            rdy_g, err_g, lock_g, rdy_u, err_u, lock_u;
    logic [NCH-1:0]  clk_g, clk_u;

    always #5 refclk = ~refclk;

    clkgen_multi #(.NUM_CLOCKS(NCH), .CNT_W(CW), .DEF_DIV(DEFD), .LOCK_CYCLES(LC),
                   .GATE_UNLOCKED(1)) u_dut_g (
        .refclk(refclk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(rdy_g),
        .cfg_chan(cfg_chan), .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
        .cfg_err(err_g), .outclk(clk_g), .locked(lock_g));

    clkgen_multi #(.NUM_CLOCKS(NCH), .CNT_W(CW), .DEF_DIV(DEFD), .LOCK_CYCLES(LC),
                   .GATE_UNLOCKED(0)) u_dut_u (
        .refclk(refclk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(rdy_u),
        .cfg_chan(cfg_chan), .cfg_div(cfg_div), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
        .cfg_err(err_u), .outclk(clk_u), .locked(lock_u));

    int n_vec = 0;
    int n_err = 0;

    // Model: each channel's waveform is a pure function of time since the last
    // reference point (reset release or configuration apply).
    int m_edge, m_ref;
    bit m_pend, m_ready, m_locked, m_err;
    int a_div[NCH], a_high[NCH], a_ph[NCH];
    int s_div[NCH], s_high[NCH], s_ph[NCH];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, m_edge);
        end
    endtask

    function automatic bit exp_clk(input int i);
        int c;
        c = (m_edge - m_ref - a_ph[i]) % a_div[i];
        if (c < 0) c += a_div[i];
        return (c < a_high[i]);
    endfunction

    task automatic model_reset();
        m_edge = 0; m_ref = 0;
        m_pend = 0; m_ready = 0; m_locked = 0; m_err = 0;
        for (int i = 0; i < NCH; i++) begin
            a_div[i] = DEFD; a_high[i] = (DEFD / 2 < 1) ? 1 : DEFD / 2; a_ph[i] = 0;
            s_div[i] = a_div[i]; s_high[i] = a_high[i]; s_ph[i] = 0;
        end
    endtask

    task automatic check_all();
        chk("locked", {31'b0, lock_g}, {31'b0, m_locked});
        chk("cfg_ready", {31'b0, rdy_g}, {31'b0, m_ready});
        chk("cfg_err", {31'b0, err_g}, {31'b0, m_err});
        chk("locked_ungated", {31'b0, lock_u}, {31'b0, m_locked});
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("outclk_gated[%0d]", i), {31'b0, clk_g[i]},
                {31'b0, exp_clk(i) & m_locked});
            chk($sformatf("outclk_ungated[%0d]", i), {31'b0, clk_u[i]}, {31'b0, exp_clk(i)});
        end
    endtask

    task automatic step(input bit v, input int ch, input int dv, input int hi, input int ph);
        bit legal;
        cfg_valid = v;
        cfg_chan  = 5'(ch);
        cfg_div   = CW'(dv);
        cfg_high  = CW'(hi);
        cfg_phase = CW'(ph);
        @(posedge refclk);
        m_edge++;
        m_err = 0;
        legal = (ch < NCH) && (dv >= 2) && (hi >= 1) && (hi < dv) && (ph < dv);
        if (m_pend) begin
            m_pend = 0;
            m_ref  = m_edge;
            for (int i = 0; i < NCH; i++) begin
                a_div[i] = s_div[i]; a_high[i] = s_high[i]; a_ph[i] = s_ph[i];
            end
        end else if (v && m_ready) begin
            if (legal) begin
                s_div[ch] = dv; s_high[ch] = hi; s_ph[ch] = ph;
                m_pend = 1;
            end else begin
                m_err = 1;
            end
        end
        m_ready  = !m_pend;
        m_locked = !m_pend && ((m_edge - m_ref) >= LC);
        #1;
        check_all();
    endtask

    task automatic idle(input int k);
        for (int j = 0; j < k; j++) step(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_outclk_gated", {30'b0, clk_g}, 32'd0);
        chk("rst_outclk_ungated", {30'b0, clk_u}, 32'd0);
        chk("rst_locked", {31'b0, lock_g}, 32'd0);
        chk("rst_cfg_ready", {31'b0, rdy_g}, 32'd0);
        chk("rst_cfg_err", {31'b0, err_g}, 32'd0);
        @(negedge refclk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        do_reset();
        idle(20);
        step(1, 1, 4, 1, 3);
        idle(20);
        step(1, 0, 1, 1, 0);
        idle(3);
        step(1, 0, 4, 4, 0);
        idle(3);
        step(1, NCH, 4, 1, 0);
        idle(3);
        step(1, 0, 6, 5, 1);
        idle(3);
        step(1, 0, 6, 3, 2);
        idle(12);
        step(1, 1, 3, 2, 0);
        do_reset();
        idle(20);
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 23) == 0) begin
                int dv, hi, ph, ch;
                ch = int'($urandom_range(0, NCH));
                dv = int'($urandom_range(0, 9));
                hi = int'($urandom_range(0, dv + 1));
                ph = int'($urandom_range(0, dv));
                step(1, ch, dv, hi, ph);
            end else begin
                step(0, int'($urandom_range(0, 3)), int'($urandom_range(0, 9)),
                     int'($urandom_range(0, 9)), int'($urandom_range(0, 9)));
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
